// File: rtl/rps_pkg.sv
// rps_pkg -- shared types for the rock/paper/scissors round controller.
//   move_t   : encoded player move (11 is illegal and never latched)
//   result_t : round outcome as presented on the result output
//   state_t  : round controller FSM states
//   beats()  : standard RPS win rule, true when a beats b
package rps_pkg;

  typedef enum logic [1:0] {
    MV_ROCK     = 2'b00,
    MV_PAPER    = 2'b01,
    MV_SCISSORS = 2'b10,
    MV_ILLEGAL  = 2'b11
  } move_t;

  typedef enum logic [1:0] {
    RES_DRAW = 2'b00,
    RES_P1   = 2'b01,
    RES_P2   = 2'b10
  } result_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_ARM,
    ST_PLAY,
    ST_JUDGE,
    ST_SHOW,
    ST_OVER
  } state_t;

  function automatic logic beats(move_t a, move_t b);
    return ((a == MV_ROCK)     && (b == MV_SCISSORS)) ||
           ((a == MV_PAPER)    && (b == MV_ROCK))     ||
           ((a == MV_SCISSORS) && (b == MV_PAPER));
  endfunction

endpackage

// File: rtl/rps_round_ctrl_if.sv
// rps_round_ctrl_if -- player, timer and result signals of rps_round_ctrl.
//   start                   : one-cycle match start request
//   p1/p2_valid, p1/p2_move : player move strobes and moves
//   timer_done              : round timer hit_target (high when idle/expired)
//   timer_rst, timer_start  : round timer sync reset and count level
//   result, result_valid    : round outcome and its one-cycle qualifier
//   p1/p2_score, match_over : running match state
// master drives the player/timer inputs, slave is the controller.
interface rps_round_ctrl_if
  import rps_pkg::*;
#(
  parameter int unsigned SCORE_W = 3
);
  logic               start;
  logic               p1_valid;
  logic               p2_valid;
  move_t              p1_move;
  move_t              p2_move;
  logic               timer_done;
  logic               timer_rst;
  logic               timer_start;
  result_t            result;
  logic               result_valid;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic               match_over;

  modport master (
    output start, p1_valid, p2_valid, p1_move, p2_move, timer_done,
    input  timer_rst, timer_start, result, result_valid,
           p1_score, p2_score, match_over
  );

  modport slave (
    input  start, p1_valid, p2_valid, p1_move, p2_move, timer_done,
    output timer_rst, timer_start, result, result_valid,
           p1_score, p2_score, match_over
  );
endinterface

// File: rtl/rps_judge.sv
// rps_judge -- combinational round judge.
//   p1_move_i/p2_move_i : latched moves
//   p1_has_i/p2_has_i   : move presence flags
//   result_o            : both present -> RPS rule, one present -> that
//                         player wins, none -> draw
module rps_judge
  import rps_pkg::*;
(
  input  move_t   p1_move_i,
  input  move_t   p2_move_i,
  input  logic    p1_has_i,
  input  logic    p2_has_i,
  output result_t result_o
);
  always_comb begin
    result_o = RES_DRAW;
    if (p1_has_i && p2_has_i) begin
      if (beats(p1_move_i, p2_move_i))      result_o = RES_P1;
      else if (beats(p2_move_i, p1_move_i)) result_o = RES_P2;
    end else if (p1_has_i) begin
      result_o = RES_P1;
    end else if (p2_has_i) begin
      result_o = RES_P2;
    end
  end
endmodule

// File: rtl/rps_round_ctrl.sv
// rps_round_ctrl -- rock/paper/scissors match controller.
// Runs rounds CLR -> ARM -> PLAY -> JUDGE -> SHOW until a player reaches
// WIN_SCORE, then parks in OVER until the next start.
//   clk, reset : system clock, asynchronous active-low reset
//   bus        : rps_round_ctrl_if.slave (players, round timer, results)
//   draw_count : only when RPS_DRAW_COUNT_EN is defined; saturating count
//                of drawn rounds, cleared with the scores
// All outputs are registered.
module rps_round_ctrl
  import rps_pkg::*;
#(
  parameter int unsigned WIN_SCORE = 3,
  parameter int unsigned SCORE_W   = 3
) (
  input  logic               clk,
  input  logic               reset,
  rps_round_ctrl_if.slave    bus
`ifdef RPS_DRAW_COUNT_EN
  ,
  output logic [SCORE_W-1:0] draw_count
`endif
);

  localparam logic [SCORE_W-1:0] WIN_Q = SCORE_W'(WIN_SCORE);

  state_t             state_q;
  move_t              p1_mv_q, p2_mv_q, p1_mv_d, p2_mv_d;
  logic               p1_has_q, p2_has_q, p1_has_d, p2_has_d;
  logic               p1_take, p2_take;
  result_t            result_q, judge_res;
  logic               result_valid_q;
  logic [SCORE_W-1:0] p1_score_q, p2_score_q;
  logic               timer_rst_q, timer_start_q, match_over_q;
  logic               win_hit;
`ifdef RPS_DRAW_COUNT_EN
  logic [SCORE_W-1:0] draw_q;
`endif

  // First legal move wins; a strobe coinciding with expiry still counts
  // because the PLAY exit below uses the _d view.
  assign p1_take  = (state_q == ST_PLAY) && bus.p1_valid && !p1_has_q &&
                    (bus.p1_move != MV_ILLEGAL);
  assign p2_take  = (state_q == ST_PLAY) && bus.p2_valid && !p2_has_q &&
                    (bus.p2_move != MV_ILLEGAL);
  assign p1_has_d = p1_has_q | p1_take;
  assign p2_has_d = p2_has_q | p2_take;
  assign p1_mv_d  = p1_take ? bus.p1_move : p1_mv_q;
  assign p2_mv_d  = p2_take ? bus.p2_move : p2_mv_q;
  assign win_hit  = (p1_score_q == WIN_Q) || (p2_score_q == WIN_Q);

  rps_judge u_judge (
    .p1_move_i (p1_mv_q),
    .p2_move_i (p2_mv_q),
    .p1_has_i  (p1_has_q),
    .p2_has_i  (p2_has_q),
    .result_o  (judge_res)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      p1_mv_q        <= MV_ROCK;
      p2_mv_q        <= MV_ROCK;
      p1_has_q       <= 1'b0;
      p2_has_q       <= 1'b0;
      result_q       <= RES_DRAW;
      result_valid_q <= 1'b0;
      p1_score_q     <= '0;
      p2_score_q     <= '0;
      timer_rst_q    <= 1'b1;
      timer_start_q  <= 1'b0;
      match_over_q   <= 1'b0;
`ifdef RPS_DRAW_COUNT_EN
      draw_q         <= '0;
`endif
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_OVER: begin
          timer_rst_q   <= 1'b0;
          timer_start_q <= 1'b0;
          if (bus.start) begin
            state_q      <= ST_CLR;
            p1_score_q   <= '0;
            p2_score_q   <= '0;
            match_over_q <= 1'b0;
            timer_rst_q  <= 1'b1;   // high for exactly the CLR cycle
`ifdef RPS_DRAW_COUNT_EN
            draw_q       <= '0;
`endif
          end
        end
        ST_CLR: begin
          timer_rst_q   <= 1'b0;
          timer_start_q <= 1'b1;
          p1_has_q      <= 1'b0;
          p2_has_q      <= 1'b0;
          state_q       <= ST_ARM;
        end
        ST_ARM: begin
          // timer_done is still the idle indication here, not expiry
          if (!bus.timer_done) state_q <= ST_PLAY;
        end
        ST_PLAY: begin
          p1_has_q <= p1_has_d;
          p2_has_q <= p2_has_d;
          p1_mv_q  <= p1_mv_d;
          p2_mv_q  <= p2_mv_d;
          if ((p1_has_d && p2_has_d) || bus.timer_done) begin
            state_q       <= ST_JUDGE;
            timer_start_q <= 1'b0;
          end
        end
        ST_JUDGE: begin
          result_q       <= judge_res;
          result_valid_q <= 1'b1;     // high during SHOW
          state_q        <= ST_SHOW;
          if (judge_res == RES_P1 && p1_score_q != WIN_Q)
            p1_score_q <= p1_score_q + 1'b1;
          if (judge_res == RES_P2 && p2_score_q != WIN_Q)
            p2_score_q <= p2_score_q + 1'b1;
`ifdef RPS_DRAW_COUNT_EN
          if (judge_res == RES_DRAW && draw_q != '1)
            draw_q <= draw_q + 1'b1;
`endif
        end
        ST_SHOW: begin
          if (win_hit) begin
            state_q      <= ST_OVER;
            match_over_q <= 1'b1;
          end else begin
            state_q     <= ST_CLR;
            timer_rst_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.timer_rst    = timer_rst_q;
  assign bus.timer_start  = timer_start_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.p1_score     = p1_score_q;
  assign bus.p2_score     = p2_score_q;
  assign bus.match_over   = match_over_q;
`ifdef RPS_DRAW_COUNT_EN
  assign draw_count       = draw_q;
`endif

endmodule
